serial_fifo_slave: RTL and testbench

Wishbone slave bridging the system bus to the byte-wide on-board UART transmitter/receiver pair, with parametrised RX and TX FIFOs, a status register and sticky overrun detection. It is the buffered successor to the unbuffered serial port slave. It sits between the bus interconnect and the async UART modules in the top level, and runs entirely in the bus clock domain.

---
 rtl/serial_fifo_slave.sv | 204 ++++++++++++++++++++
 tb/tb_serial_fifo_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_fifo_slave.sv
// ============================================================================
// Module   : serial_fifo_slave
// Brief    : Wishbone slave with RX/TX byte FIFOs bridging the bus to a UART
//            pair. Optional interrupt output under macro SERIAL_FIFO_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fifo_slave #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk_bus,
  input  logic        rst_bus_n,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        stall_o,
  input  logic [7:0]  uart_dat_i,
  input  logic        uart_ready,
  output logic [7:0]  uart_dat_o,
  output logic        uart_start,
  input  logic        uart_busy
`ifdef SERIAL_FIFO_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int c_rx_depth = 1 << RX_DEPTH_LOG2;
  localparam int c_tx_depth = 1 << TX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] c_rx_full = (RX_DEPTH_LOG2 + 1)'(c_rx_depth);
  localparam logic [TX_DEPTH_LOG2:0] c_tx_full = (TX_DEPTH_LOG2 + 1)'(c_tx_depth);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  logic [7:0]               r_rx_mem [c_rx_depth];
  logic [RX_DEPTH_LOG2-1:0] r_rx_wptr, r_rx_rptr;
  logic [RX_DEPTH_LOG2:0]   r_rx_count;
  logic [7:0]               r_tx_mem [c_tx_depth];
  logic [TX_DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr;
  logic [TX_DEPTH_LOG2:0]   r_tx_count;

  logic       r_ovr, r_ack, r_err, r_rty, r_tx_avail;
  logic [3:0] r_timer;
  logic [1:0] r_en;
  state_t     r_state;

  logic        w_req, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, w_tx_idle;
  logic        w_rx_pop, w_rx_push, w_ovr_set, w_tx_push, w_tx_pop, w_ovr_clr;
  logic [1:0]  w_off;
  logic [31:0] w_status, w_ctrl_rd;
  logic        w_unused;

  assign w_req      = cyc_i & stb_i;
  assign w_off      = adr_i[3:2];
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_full  = (r_rx_count == c_rx_full);
  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == c_tx_full);
  assign w_tx_idle  = w_tx_empty & (r_state == ST_IDLE);

  // A pop frees a slot for a same-cycle push, so a full RX FIFO only
  // overruns when no bus read is draining it on that edge.
  assign w_rx_pop  = w_req & ~we_i & (w_off == 2'd0) & ~w_rx_empty;
  assign w_rx_push = uart_ready & (~w_rx_full | w_rx_pop);
  assign w_ovr_set = uart_ready & w_rx_full & ~w_rx_pop;
  assign w_ovr_clr = w_req & we_i & (w_off == 2'd2) & dat_i[3];
  assign w_tx_push = w_req & we_i & (w_off == 2'd0) & ~w_tx_full;
  assign w_tx_pop  = (r_state == ST_IDLE) & r_tx_avail & ~w_tx_empty & ~uart_busy;

  assign w_status = {8'h00, 8'(r_tx_count), 8'(r_rx_count), 4'h0,
                     r_ovr, w_tx_idle, ~w_tx_full, ~w_rx_empty};
`ifdef SERIAL_FIFO_IRQ_EN
  assign w_ctrl_rd = {30'd0, r_en};
`else
  assign w_ctrl_rd = 32'd0;
`endif

  assign ack_o    = r_ack & cyc_i;
  assign err_o    = r_err & cyc_i;
  assign rty_o    = r_rty & cyc_i;
  assign stall_o  = 1'b0;
  assign w_unused = ^{dat_i[31:8], adr_i[31:4], adr_i[1:0], sel_i};

  always_ff @(posedge clk_bus) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= uart_dat_i;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= dat_i[7:0];
  end

  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
      r_ovr      <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rty      <= 1'b0;
      r_en       <= 2'b00;
      dat_o      <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_rx_push & ~w_rx_pop) r_rx_count <= r_rx_count + 1'b1;
      else if (~w_rx_push & w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_push & ~w_tx_pop) r_tx_count <= r_tx_count + 1'b1;
      else if (~w_tx_push & w_tx_pop) r_tx_count <= r_tx_count - 1'b1;
      if (w_ovr_set)      r_ovr <= 1'b1;
      else if (w_ovr_clr) r_ovr <= 1'b0;
      if (w_req) begin
        case (w_off)
          2'd0: begin
            if (we_i) begin
              r_ack <= ~w_tx_full;
              r_rty <= w_tx_full;
            end else begin
              r_ack <= 1'b1;
              dat_o <= w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rptr]};
            end
          end
          2'd1: begin
            r_ack <= ~we_i;
            r_err <= we_i;
            if (!we_i) dat_o <= w_status;
          end
          2'd2: begin
            r_ack <= 1'b1;
            if (!we_i) dat_o <= w_ctrl_rd;
`ifdef SERIAL_FIFO_IRQ_EN
            if (we_i) r_en <= dat_i[1:0];
`endif
          end
          default: r_err <= 1'b1;
        endcase
      end
    end
  end

  // r_tx_avail lags the count by one edge, which sets the write-to-start
  // latency at two cycles.
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= 4'd0;
      r_tx_avail <= 1'b0;
      uart_start <= 1'b0;
      uart_dat_o <= 8'd0;
    end else begin
      uart_start <= 1'b0;
      r_tx_avail <= ~w_tx_empty;
      case (r_state)
        ST_IDLE: begin
          if (w_tx_pop) begin
            uart_dat_o <= r_tx_mem[r_tx_rptr];
            uart_start <= 1'b1;
            r_timer    <= 4'd0;
            r_state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (uart_busy)              r_state <= ST_DRAIN;
          else if (r_timer == 4'hF)   r_state <= ST_IDLE;
          else                        r_timer <= r_timer + 4'd1;
        end
        ST_DRAIN: begin
          if (!uart_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIAL_FIFO_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk_bus or negedge rst_bus_n) begin
    if (!rst_bus_n) r_irq <= 1'b0;
    else            r_irq <= (r_en[0] & ~w_rx_empty) | (r_en[1] & w_tx_idle);
  end
  assign irq_o = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_fifo_slave.sv
// ============================================================================
// Module   : tb_serial_fifo_slave
// Brief    : Directed self-checking bench for serial_fifo_slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_fifo_slave;

  logic        clk_bus = 1'b0;
  logic        rst_bus_n = 1'b0;
  logic [31:0] dat_i = '0, adr_i = '0, dat_o;
  logic [3:0]  sel_i = 4'h0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic        ack_o, err_o, rty_o, stall_o;
  logic [7:0]  uart_dat_i = '0, uart_dat_o;
  logic        uart_ready = 1'b0, uart_busy = 1'b0, uart_start;
`ifdef SERIAL_FIFO_IRQ_EN
  logic        irq_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_bus = ~clk_bus;

  serial_fifo_slave dut (
    .clk_bus(clk_bus), .rst_bus_n(rst_bus_n),
    .dat_i(dat_i), .dat_o(dat_o), .adr_i(adr_i), .sel_i(sel_i),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o), .stall_o(stall_o),
    .uart_dat_i(uart_dat_i), .uart_ready(uart_ready),
    .uart_dat_o(uart_dat_o), .uart_start(uart_start), .uart_busy(uart_busy)
`ifdef SERIAL_FIFO_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  // One bus request per call; consecutive calls are back-to-back cycles.
  task automatic bus(input logic we, input logic [1:0] off, input logic [31:0] wd,
                     output logic a, output logic e, output logic r, output logic [31:0] rd);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; dat_i = wd;
    adr_i = {28'hABCDE12, off, 2'b11};
    sel_i = 4'h1;
    @(posedge clk_bus); #1;
    a = ack_o; e = err_o; r = rty_o; rd = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    uart_dat_i = d; uart_ready = 1'b1;
    @(posedge clk_bus); #1;
    uart_ready = 1'b0;
    @(posedge clk_bus); #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_bus); #1;
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic a, e, r;
    logic [31:0] rd;
    bus(1'b0, 2'd1, 32'd0, a, e, r, rd);
    n_tests++;
    if (rd !== exp || a !== 1'b1 || e !== 1'b0 || r !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: status=%h ack=%b err=%b rty=%b, required status=%h ack=1", name, rd, a, e, r, exp);
    end
  endtask

  task automatic test_reset();
    rst_bus_n = 1'b0;
    #2;
    n_tests++;
    if ({ack_o, err_o, rty_o, uart_start, stall_o} !== 5'b0 || dat_o !== 32'd0 || uart_dat_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack/err/rty/start/stall=%b dat_o=%h uart_dat_o=%h, required all 0",
               {ack_o, err_o, rty_o, uart_start, stall_o}, dat_o, uart_dat_o);
    end
    @(negedge clk_bus); @(negedge clk_bus);
    rst_bus_n = 1'b1;
    @(posedge clk_bus); #1;
    check_status("reset_status", 32'h0000_0006);
  endtask

  task automatic test_tx_single();
    logic a, e, r;
    logic [31:0] rd;
    uart_busy = 1'b0;
    bus(1'b1, 2'd0, 32'h0000_0141, a, e, r, rd);
    n_tests++;
    if (a !== 1'b1 || r !== 1'b0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_write_ack: ack=%b err=%b rty=%b, required ack=1", a, e, r);
    end
    @(posedge clk_bus); #1;
    n_tests++;
    if (uart_start !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_start_early: uart_start=%b one cycle after write, required 0", uart_start);
    end
    @(posedge clk_bus); #1;
    n_tests++;
    if (uart_start !== 1'b1 || uart_dat_o !== 8'h41) begin
      n_fail++;
      $display("FAIL tx_start: uart_start=%b uart_dat_o=%h, required 1 and 41", uart_start, uart_dat_o);
    end
    @(posedge clk_bus); #1;
    n_tests++;
    if (uart_start !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_start_pulse: uart_start=%b, required 0 after one cycle", uart_start);
    end
    wait_cycles(25);
    check_status("tx_idle_after_timeout", 32'h0000_0006);
  endtask

  task automatic test_rx_overrun();
    logic a, e, r;
    logic [31:0] rd;
    for (int i = 0; i <= 16; i++) rx_pulse(8'(i));
    check_status("rx_overrun_status", 32'h0000_100F);
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 2'd0, 32'd0, a, e, r, rd);
      n_tests++;
      if (a !== 1'b1 || rd !== 32'(i)) begin
        n_fail++;
        $display("FAIL rx_read_%0d: ack=%b data=%h, required ack=1 data=%h", i, a, rd, 32'(i));
      end
    end
    check_status("rx_overrun_sticky", 32'h0000_000E);
    bus(1'b1, 2'd2, 32'h0000_0008, a, e, r, rd);
    n_tests++;
    if (a !== 1'b1 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_clear_ack: ack=%b err=%b, required ack=1", a, e);
    end
    check_status("rx_overrun_cleared", 32'h0000_0006);
  endtask

  task automatic test_empty_and_err();
    logic a, e, r;
    logic [31:0] rd, exp_ctrl;
    bus(1'b0, 2'd0, 32'd0, a, e, r, rd);
    n_tests++;
    if (a !== 1'b1 || e !== 1'b0 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL rx_empty_read: ack=%b err=%b data=%h, required ack=1 data=0", a, e, rd);
    end
    bus(1'b0, 2'd3, 32'd0, a, e, r, rd);
    n_tests++;
    if (e !== 1'b1 || a !== 1'b0 || r !== 1'b0) begin
      n_fail++;
      $display("FAIL offset3_err: ack=%b err=%b rty=%b, required err=1 only", a, e, r);
    end
    bus(1'b1, 2'd1, 32'hFFFF_FFFF, a, e, r, rd);
    n_tests++;
    if (e !== 1'b1 || a !== 1'b0) begin
      n_fail++;
      $display("FAIL status_write_err: ack=%b err=%b, required err=1", a, e);
    end
    bus(1'b1, 2'd2, 32'h0000_0003, a, e, r, rd);
    bus(1'b0, 2'd2, 32'd0, a, e, r, rd);
`ifdef SERIAL_FIFO_IRQ_EN
    exp_ctrl = 32'h0000_0003;
`else
    exp_ctrl = 32'h0000_0000;
`endif
    n_tests++;
    if (a !== 1'b1 || rd !== exp_ctrl) begin
      n_fail++;
      $display("FAIL ctrl_readback: ack=%b data=%h, required ack=1 data=%h", a, rd, exp_ctrl);
    end
    bus(1'b1, 2'd2, 32'h0000_0000, a, e, r, rd);
    check_status("after_err_status", 32'h0000_0006);
  endtask

  task automatic test_rx_full_concurrent();
    logic a, e, r;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) rx_pulse(8'(8'h20 + i));
    uart_dat_i = 8'h30; uart_ready = 1'b1;
    bus(1'b0, 2'd0, 32'd0, a, e, r, rd);
    uart_ready = 1'b0;
    n_tests++;
    if (a !== 1'b1 || rd !== 32'h20) begin
      n_fail++;
      $display("FAIL concurrent_pop: ack=%b data=%h, required ack=1 data=20", a, rd);
    end
    check_status("concurrent_status", 32'h0000_1007);
    for (int i = 0; i < 16; i++) begin
      bus(1'b0, 2'd0, 32'd0, a, e, r, rd);
      n_tests++;
      if (a !== 1'b1 || rd !== 32'(8'h21 + i)) begin
        n_fail++;
        $display("FAIL concurrent_drain_%0d: ack=%b data=%h, required ack=1 data=%h", i, a, rd, 32'(8'h21 + i));
      end
    end
    check_status("concurrent_empty", 32'h0000_0006);
  endtask

  task automatic test_tx_full();
    logic a, e, r;
    logic [31:0] rd;
    uart_busy = 1'b1;
    wait_cycles(1);
    for (int i = 0; i < 17; i++) begin
      bus(1'b1, 2'd0, 32'(i), a, e, r, rd);
      n_tests++;
      if (i < 16 && (a !== 1'b1 || r !== 1'b0)) begin
        n_fail++;
        $display("FAIL tx_fill_%0d: ack=%b rty=%b, required ack=1 rty=0", i, a, r);
      end else if (i == 16 && (a !== 1'b0 || r !== 1'b1)) begin
        n_fail++;
        $display("FAIL tx_full_rty: ack=%b rty=%b, required ack=0 rty=1", a, r);
      end
    end
    check_status("tx_full_status", 32'h0010_0000);
  endtask

  task automatic test_reset_mid_drain();
    logic a, e, r;
    logic [31:0] rd;
    rst_bus_n = 1'b0; #3; rst_bus_n = 1'b1;
    @(posedge clk_bus); #1;
    uart_busy = 1'b1;
    for (int i = 0; i < 6; i++) bus(1'b1, 2'd0, 32'(8'hA0 + i), a, e, r, rd);
    wait_cycles(2);
    uart_busy = 1'b0;
    @(posedge clk_bus); #1;
    uart_busy = 1'b1;
    n_tests++;
    if (uart_start !== 1'b1 || uart_dat_o !== 8'hA0) begin
      n_fail++;
      $display("FAIL drain_launch: uart_start=%b uart_dat_o=%h, required 1 and a0", uart_start, uart_dat_o);
    end
    check_status("drain_status", 32'h0005_0002);
    #3 rst_bus_n = 1'b0;
    #1;
    n_tests++;
    if ({ack_o, err_o, rty_o, uart_start} !== 4'b0 || dat_o !== 32'd0 || uart_dat_o !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: ack/err/rty/start=%b dat_o=%h uart_dat_o=%h, required all 0",
               {ack_o, err_o, rty_o, uart_start}, dat_o, uart_dat_o);
    end
    #2 rst_bus_n = 1'b1;
    uart_busy = 1'b0;
    @(posedge clk_bus); #1;
    check_status("post_reset_status", 32'h0000_0006);
  endtask

`ifdef SERIAL_FIFO_IRQ_EN
  task automatic test_irq();
    logic a, e, r;
    logic [31:0] rd;
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_reset: irq_o=%b, required 0", irq_o);
    end
    bus(1'b1, 2'd2, 32'h0000_0001, a, e, r, rd);
    uart_dat_i = 8'h55; uart_ready = 1'b1;
    @(posedge clk_bus); #1;
    uart_ready = 1'b0;
    n_tests++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_early: irq_o=%b on push cycle, required 0", irq_o);
    end
    @(posedge clk_bus); #1;
    n_tests++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rx: irq_o=%b, required 1", irq_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_single();
    test_rx_overrun();
    test_empty_and_err();
    test_rx_full_concurrent();
    test_tx_full();
    test_reset_mid_drain();
`ifdef SERIAL_FIFO_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
